// File: rtl/bp_fpga_host_tx_arbiter.sv
// Round-robin arbiter between two NBF packet sources that serializes the
// granted packet into UART-sized bytes: opcode first, then addr and data LSB-first.
module bp_fpga_host_tx_arbiter #(
   parameter int nbf_addr_width_p = 40,
   parameter int nbf_data_width_p = 64,
   parameter int uart_data_bits_p = 8
) (
   input  logic                                               clk_i,
   input  logic                                               reset_i,

   input  logic [8+nbf_addr_width_p+nbf_data_width_p-1:0]     nbf0_i,
   input  logic                                               nbf0_v_i,
   output logic                                               nbf0_ready_and_o,

   input  logic [8+nbf_addr_width_p+nbf_data_width_p-1:0]     nbf1_i,
   input  logic                                               nbf1_v_i,
   output logic                                               nbf1_ready_and_o,

   output logic [uart_data_bits_p-1:0]                        tx_data_o,
   output logic                                               tx_v_o,
   input  logic                                               tx_ready_and_i,

   output logic [15:0]                                        pkt_cnt0_o,
   output logic [15:0]                                        pkt_cnt1_o
);

   localparam int pkt_width_lp = 8 + nbf_addr_width_p + nbf_data_width_p;
   localparam int num_bytes_lp = pkt_width_lp / uart_data_bits_p;
   localparam int cnt_width_lp = $clog2(num_bytes_lp);
   localparam logic [cnt_width_lp-1:0] last_byte_lp = cnt_width_lp'(num_bytes_lp - 1);

   typedef enum logic {
      IDLE,
      SEND
   } state_e;

   state_e                    state_q, state_d;
   logic [cnt_width_lp-1:0]   cnt_q, cnt_d;
   logic                      last_q, last_d;
   logic [pkt_width_lp-1:0]   pkt_q, pkt_d;
   logic [15:0]               pkt_cnt0_q, pkt_cnt0_d;
   logic [15:0]               pkt_cnt1_q, pkt_cnt1_d;

   logic                      ready0, ready1;
   logic [pkt_width_lp-1:0]   ser;

   // Grant depends only on state, valids and the last grant; reset masks it.
   always_comb begin
      ready0 = 1'b0;
      ready1 = 1'b0;
      if (!reset_i && (state_q == IDLE)) begin
         ready0 = nbf0_v_i && (!nbf1_v_i || last_q);
         ready1 = nbf1_v_i && (!nbf0_v_i || !last_q);
      end
   end

   // Reorder the packet so byte k of the wire order is simply slice k.
   assign ser = {pkt_q[nbf_data_width_p-1:0],
                 pkt_q[nbf_data_width_p +: nbf_addr_width_p],
                 pkt_q[pkt_width_lp-1 -: 8]};

   assign tx_data_o        = ser[int'(cnt_q)*uart_data_bits_p +: uart_data_bits_p];
   assign tx_v_o           = (state_q == SEND);
   assign nbf0_ready_and_o = ready0;
   assign nbf1_ready_and_o = ready1;
   assign pkt_cnt0_o       = pkt_cnt0_q;
   assign pkt_cnt1_o       = pkt_cnt1_q;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      last_d     = last_q;
      pkt_d      = pkt_q;
      pkt_cnt0_d = pkt_cnt0_q;
      pkt_cnt1_d = pkt_cnt1_q;

      unique case (state_q)
         IDLE: begin
            if (nbf0_v_i && ready0) begin
               pkt_d   = nbf0_i;
               last_d  = 1'b0;
               cnt_d   = '0;
               state_d = SEND;
            end else if (nbf1_v_i && ready1) begin
               pkt_d   = nbf1_i;
               last_d  = 1'b1;
               cnt_d   = '0;
               state_d = SEND;
            end
         end

         SEND: begin
            if (tx_ready_and_i) begin
               if (cnt_q == last_byte_lp) begin
                  state_d = IDLE;
                  cnt_d   = '0;
                  if (last_q) begin
                     pkt_cnt1_d = (pkt_cnt1_q == '1) ? pkt_cnt1_q : pkt_cnt1_q + 16'd1;
                  end else begin
                     pkt_cnt0_d = (pkt_cnt0_q == '1) ? pkt_cnt0_q : pkt_cnt0_q + 16'd1;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         last_q     <= 1'b1;
         pkt_q      <= '0;
         pkt_cnt0_q <= '0;
         pkt_cnt1_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         last_q     <= last_d;
         pkt_q      <= pkt_d;
         pkt_cnt0_q <= pkt_cnt0_d;
         pkt_cnt1_q <= pkt_cnt1_d;
      end
   end

endmodule

// File: doc/bp_fpga_host_tx_arbiter.md
BP_FPGA_HOST_TX_ARBITER -- requirements
Module: bp_fpga_host_tx_arbiter

Interface
REQ-001 The block SHALL have parameter nbf_addr_width_p, default 40, giving the NBF address field width in bits.
REQ-002 The block SHALL have parameter nbf_data_width_p, default 64, giving the NBF data field width in bits.
REQ-003 The block SHALL have parameter uart_data_bits_p, default 8, giving the serialized byte width in bits.
REQ-004 The block SHALL have port clk_i, input, 1 bit: the single clock.
REQ-005 The block SHALL have port reset_i, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port nbf0_i, input, 112 bits: source-0 packet, packed {opcode[7:0], addr[39:0], data[63:0]}; source 0 is the io_in ack/error path.
REQ-007 The block SHALL have ports nbf0_v_i (input, 1 bit) and nbf0_ready_and_o (output, 1 bit): the source-0 handshake.
REQ-008 The block SHALL have port nbf1_i, input, 112 bits: source-1 packet; source 1 is the io_out BP command path.
REQ-009 The block SHALL have ports nbf1_v_i (input, 1 bit) and nbf1_ready_and_o (output, 1 bit): the source-1 handshake.
REQ-010 The block SHALL have port tx_data_o, output, 8 bits: the byte to the UART transmitter.
REQ-011 The block SHALL have ports tx_v_o (output, 1 bit) and tx_ready_and_i (input, 1 bit): the byte handshake.
REQ-012 The block SHALL have ports pkt_cnt0_o and pkt_cnt1_o, outputs, 16 bits each: completed-packet counts per source.

Function
REQ-013 The block SHALL use a state machine with two states, IDLE and SEND.
REQ-014 In IDLE, the block SHALL assert at most one nbfX_ready_and_o, for the granted source only.
REQ-015 Grant SHALL be round-robin. With one source valid, that source is granted. With both valid, the source not granted last is granted.
REQ-016 The last-grant register SHALL reset to 1, so source 0 wins the first tie.
REQ-017 When nbfX_v_i and nbfX_ready_and_o are both high, the block SHALL capture the packet into a 112-bit register, record the grant, clear the byte counter to 0, and enter SEND the next cycle.
REQ-018 In SEND, both nbfX_ready_and_o SHALL be low. Packets are atomic; bytes from two packets are never interleaved.
REQ-019 In SEND, tx_v_o SHALL be high and tx_data_o SHALL equal byte k of the captured packet.
REQ-020 Byte order SHALL be: byte 0 = opcode; bytes 1-5 = addr, LSB first; bytes 6-13 = data, LSB first.
REQ-021 The byte counter SHALL advance by one on each cycle where tx_v_o and tx_ready_and_i are both high, and SHALL hold otherwise.
REQ-022 tx_data_o SHALL be stable while tx_v_o is high and tx_ready_and_i is low.
REQ-023 On the handshake of byte 13, the block SHALL return to IDLE and increment the packet counter of the granted source.
REQ-024 A new packet SHALL be accepted no earlier than the cycle after the return to IDLE. Minimum packet period is 15 cycles.
REQ-025 Latency SHALL be one cycle: the first byte is valid the cycle after packet acceptance.
REQ-026 tx_v_o SHALL be low in IDLE.
REQ-027 Packet counters SHALL saturate at 16'hFFFF and SHALL not wrap.
REQ-028 Ready outputs SHALL depend on state, nbfX_v_i and the last-grant register only; they SHALL not depend on tx_ready_and_i.
REQ-029 A source dropping nbfX_v_i in IDLE before it is accepted SHALL lose the grant with no side effects.

Reset
REQ-030 Asserting reset_i SHALL immediately force: state IDLE, byte counter 0, last grant 1, pkt_cnt0_o = pkt_cnt1_o = 0, tx_v_o = 0, nbf0_ready_and_o = nbf1_ready_and_o = 0, captured packet = 0.
REQ-031 Reset asserted mid-packet SHALL discard the remaining bytes and SHALL not increment any counter.
REQ-032 After reset deasserts, the block SHALL accept a new packet on the first cycle in which a source is valid.

Verification
REQ-033 Source 0 sends opcode 0x02, addr 0x00_8000_1000, data 0x1122334455667788, with tx_ready_and_i held at 1 -> bytes 02,00,10,00,80,00,88,77,66,55,44,33,22,11 on cycles 1-14; pkt_cnt0_o = 1.
REQ-034 Both sources valid continuously for 4 packets -> grant order 0,1,0,1; pkt_cnt0_o = 2, pkt_cnt1_o = 2; no byte interleaving.
REQ-035 tx_ready_and_i toggles 1,0,0,1 repeatedly during a packet -> tx_data_o holds during stalls; all 14 bytes arrive in order.
REQ-036 Reset is asserted after byte 5 of a source-1 packet -> tx_v_o = 0 immediately, pkt_cnt1_o = 0; the next source-0 packet is sent starting from byte 0.
REQ-037 pkt_cnt0_o is preloaded (by force) to 0xFFFE, then 3 packets are sent -> pkt_cnt0_o reads 0xFFFF and stays there.
REQ-038 Source 1 is valid during SEND of a source-0 packet -> nbf1_ready_and_o stays 0 until IDLE, then source 1 is accepted the cycle after the return to IDLE.
